// File: rtl/bcd_digit_encoder.sv
// bcd_digit_encoder
//   Converts a signed two's-complement value into per-digit 4-bit display
//   codes. Each code is 0-9 for a digit, 11 for a minus sign or 15 for blank.
//   The conversion uses the iterative shift-add-3 (double dabble) method, so
//   no divider is needed. A conversion takes WIDTH shift edges and one finish
//   edge. The outputs change only on the finish edge.
//
// Ports
//   clock     : system clock, rising edge
//   reset_n   : asynchronous active-low reset
//   start     : one-cycle conversion request, honoured only when idle
//   value     : signed input, sampled when start is accepted
//   blank_lz  : 1 = show leading zeros as blank (15), sampled with value
//   busy      : high while a conversion is in progress
//   done      : one-cycle pulse when digits/sign_code hold a new result
//   digits    : digit codes, [3:0] = units, top nibble = most significant
//   sign_code : 11 if the captured value was negative, else 15
module bcd_digit_encoder #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [WIDTH-1:0]      value,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic [DIGITS*4-1:0]   digits,
  output logic [3:0]            sign_code
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = DIGITS * 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] mag_q, mag_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            neg_q, neg_d;
  logic            blank_q, blank_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [BW-1:0]   digits_q, digits_d;
  logic [3:0]      sign_q, sign_d;
  logic [BW+WIDTH-1:0] shift_s;

  // Add 3 to every BCD nibble that is 5 or more, so it carries correctly after the next doubling.
  function automatic logic [BW-1:0] add3_all(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      if (b[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
      end else begin
        r[i*4 +: 4] = b[i*4 +: 4];
      end
    end
    return r;
  endfunction

  // Blank the leading zero nibbles. The units nibble is always kept.
  function automatic logic [BW-1:0] blank_leading(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[i*4 +: 4] == 4'd0)) begin
        r[i*4 +: 4] = 4'hF;
      end else begin
        lead = 1'b0;
      end
    end
    return r;
  endfunction

  // Next-state logic for the controller, the datapath and the registered outputs.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    blank_d  = blank_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    digits_d = digits_q;
    sign_d   = sign_q;
    shift_s  = {bcd_q, mag_q};
    case (state_q)
      S_IDLE: begin
        if (start) begin
          // The negation is done in WIDTH unsigned bits, so the most negative input
          // gives 2^(WIDTH-1) with no overflow.
          if (value[WIDTH-1]) begin
            mag_d = ~value + WIDTH'(1);
          end else begin
            mag_d = value;
          end
          neg_d   = value[WIDTH-1];
          blank_d = blank_lz;
          bcd_d   = '0;
          cnt_d   = CW'(WIDTH);
          busy_d  = 1'b1;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        shift_s = {add3_all(bcd_q), mag_q} << 1;
        bcd_d   = shift_s[BW+WIDTH-1:WIDTH];
        mag_d   = shift_s[WIDTH-1:0];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = S_FINISH;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_FINISH: begin
        if (blank_q) begin
          digits_d = blank_leading(bcd_q);
        end else begin
          digits_d = bcd_q;
        end
        sign_d  = neg_q ? 4'd11 : 4'd15;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. The reset values show a blank display.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      blank_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      digits_q <= {DIGITS{4'hF}};
      sign_q   <= 4'hF;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      blank_q  <= blank_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      digits_q <= digits_d;
      sign_q   <= sign_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign digits    = digits_q;
  assign sign_code = sign_q;

endmodule

// File: tb/tb_bcd_digit_encoder.sv
// Self-checking bench for bcd_digit_encoder. It uses directed and random
// values. The expected results come from a decimal reference model based on
// modulo/divide.
module tb_bcd_digit_encoder;

  localparam int WIDTH  = 16;
  localparam int DIGITS = 5;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [WIDTH-1:0]    value = '0;
  logic                blank_lz = 1'b0;
  logic                busy;
  logic                done;
  logic [DIGITS*4-1:0] digits;
  logic [3:0]          sign_code;

  int total = 0;
  int bad   = 0;

  logic [DIGITS*4-1:0] held_digits;
  logic [3:0]          held_sign;

  bcd_digit_encoder #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .value(value),
    .blank_lz(blank_lz), .busy(busy), .done(done), .digits(digits),
    .sign_code(sign_code)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: decimal digits by repeated divide by 10.
  function automatic logic [DIGITS*4-1:0] model_digits(input logic [WIDTH-1:0] v, input logic blz);
    int mag;
    int d[DIGITS];
    logic [DIGITS*4-1:0] r;
    bit lead;
    mag = $signed(v);
    if (mag < 0) mag = -mag;
    for (int i = 0; i < DIGITS; i++) begin
      d[i] = mag % 10;
      mag  = mag / 10;
    end
    if (blz) begin
      lead = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
        if (lead && d[i] == 0) d[i] = 15;
        else lead = 1'b0;
      end
    end
    for (int i = 0; i < DIGITS; i++) r[i*4 +: 4] = 4'(d[i]);
    return r;
  endfunction

  function automatic logic [3:0] model_sign(input logic [WIDTH-1:0] v);
    return ($signed(v) < 0) ? 4'd11 : 4'd15;
  endfunction

  // One conversion. Start is pulsed again after edges g1/g2 (counting the
  // accept edge as 1) with the value 999. That pulse must be ignored.
  task automatic run_conv(input logic [WIDTH-1:0] v, input logic blz, input int g1, input int g2);
    int n;
    bit got;
    @(posedge clock); #1;
    start = 1'b1; value = v; blank_lz = blz;
    @(posedge clock); #1;
    start = 1'b0; n = 1;
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    value = WIDTH'($urandom); blank_lz = 1'($urandom);
    got = 1'b0;
    while (!got && n < 25) begin
      if (n == g1 || n == g2) begin
        start = 1'b1; value = WIDTH'(999);
      end
      @(posedge clock); #1;
      start = 1'b0;
      n++;
      if (done) begin
        got = 1'b1;
        chk("latency", n, 32'd18);
      end else begin
        chk("hold_digits", {12'd0, digits}, {12'd0, held_digits});
        chk("hold_sign", {28'd0, sign_code}, {28'd0, held_sign});
        chk("busy_during", {31'd0, busy}, 32'd1);
      end
    end
    chk("done_seen", {31'd0, got}, 32'd1);
    held_digits = model_digits(v, blz);
    held_sign   = model_sign(v);
    chk("digits", {12'd0, digits}, {12'd0, held_digits});
    chk("sign", {28'd0, sign_code}, {28'd0, held_sign});
    chk("busy_at_done", {31'd0, busy}, 32'd0);
    @(posedge clock); #1;
    chk("done_single", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] rv;
    logic             rb;
    int               g;

    held_digits = {DIGITS{4'hF}};
    held_sign   = 4'hF;

    // Check the reset values.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_digits", {12'd0, digits}, {12'd0, held_digits});
    chk("rst_sign", {28'd0, sign_code}, 32'd15);
    reset_n = 1'b1;

    // Directed values.
    run_conv(WIDTH'(1234), 1'b1, -1, -1);
    chk("dir_1234", {12'd0, digits}, 32'h000F1234);
    run_conv(16'h8000, 1'b0, -1, -1);
    chk("dir_min", {12'd0, digits}, 32'h00032768);
    run_conv(16'h7FFF, 1'b0, -1, -1);
    run_conv(WIDTH'(0), 1'b1, -1, -1);
    chk("dir_zero", {12'd0, digits}, 32'h000FFFF0);
    run_conv(16'hFFFF, 1'b1, -1, -1);
    run_conv(WIDTH'(-7), 1'b0, -1, -1);
    run_conv(WIDTH'(1234), 1'b1, 3, 10);
    run_conv(WIDTH'(999), 1'b1, -1, -1);

    // Hold start high: a new conversion every 18 edges, and busy is low only in the done cycle.
    @(posedge clock); #1;
    start = 1'b1; value = WIDTH'(42); blank_lz = 1'b1;
    for (int k = 1; k <= 54; k++) begin
      @(posedge clock); #1;
      if (k == 54) start = 1'b0;
      chk("held_done", {31'd0, done}, {31'd0, (k % 18) == 0});
      chk("held_busy", {31'd0, busy}, {31'd0, (k % 18) != 0});
      if ((k % 18) == 0) chk("held_digits", {12'd0, digits}, {12'd0, model_digits(WIDTH'(42), 1'b1)});
    end
    held_digits = model_digits(WIDTH'(42), 1'b1);
    held_sign   = 4'hF;
    @(posedge clock); #1;

    // Drop reset between edges in the middle of a conversion.
    start = 1'b1; value = WIDTH'(5555); blank_lz = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (5) @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_digits", {12'd0, digits}, 32'h000FFFFF);
    chk("abort_sign", {28'd0, sign_code}, 32'd15);
    held_digits = {DIGITS{4'hF}};
    held_sign   = 4'hF;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    run_conv(WIDTH'(-250), 1'b1, -1, -1);
    chk("dir_m250", {12'd0, digits}, 32'h000FF250);

    // Random values, some with ignored start pulses.
    for (int t = 0; t < 25; t++) begin
      rv = WIDTH'($urandom);
      rb = 1'($urandom);
      g  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(2, 16)) : -1;
      run_conv(rv, rb, g, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bcd_digit_encoder.md
Name: bcd_digit_encoder

Overview:
Sequential converter that turns a signed two's-complement result from the processor datapath into per-digit 4-bit display codes. It sits directly upstream of the 7-segment digit decoders.
- Output code set: 0-9 for decimal digits, 11 for minus sign, 15 for blank.
- One decoder instance is driven per digit output.
- Conversion uses iterative shift-add-3 (double dabble) so that no wide divider is needed.

Parameters:
WIDTH, 16, bit width of signed input value
DIGITS, 5, number of decimal digit outputs; must satisfy 10^DIGITS > 2^(WIDTH-1) (16 -> 5)

Ports:
clock  input  1  system clock, rising-edge
reset_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request to convert value; honoured only in IDLE
value  input  WIDTH  signed two's-complement number, sampled on accepted start
blank_lz  input  1  1 = replace leading zeros with blank code 15; sampled with value
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when new digits/sign are valid
digits  output  DIGITS*4  digit codes; [3:0] = units, [DIGITS*4-1:DIGITS*4-4] = most significant
sign_code  output  4  11 if captured value negative, else 15

Behaviour:
- Reset (reset_n low, asynchronous):
  - state = IDLE; busy = 0; done = 0.
  - every digits nibble = 15; sign_code = 15.
  - shift/BCD registers cleared.
- States: IDLE -> SHIFT -> FINISH -> IDLE.
- IDLE:
  - On a rising edge with start = 1, capture the following:
    - magnitude = |value|, computed as a WIDTH-bit unsigned value. -2^(WIDTH-1) gives 2^(WIDTH-1) with no overflow (e.g. -32768 -> 32768).
    - neg = value[WIDTH-1].
    - blank_lz.
  - Clear the BCD accumulator (DIGITS*4 bits), load the bit counter with WIDTH, enter SHIFT, set busy = 1.
- SHIFT:
  - Each edge: for every BCD nibble >= 5, add 3.
  - Then shift {bcd, magnitude} left by 1, with the magnitude MSB entering the BCD LSB.
  - Decrement the counter. After exactly WIDTH shift edges, go to FINISH.
- FINISH (one edge):
  - Register digits from the accumulator.
  - If captured blank_lz = 1: scan from the most significant nibble downward and replace each 0 with 15 until the first nonzero nibble. The units nibble is never blanked, so a value of 0 shows units = 0.
  - sign_code = 11 if neg else 15. Note that -0 is impossible in two's complement.
  - On the same edge: done = 1, busy = 0, state = IDLE.
- done is high for exactly one cycle, which is the cycle after the FINISH edge.
- Latency: done is high WIDTH+2 edges after the edge that accepted start (18 for WIDTH = 16).
- Outputs digits/sign_code hold their previous values throughout a conversion. They change only on the FINISH edge, so the displays never show partial results.
- start while busy = 1 (SHIFT or FINISH) is ignored. It is neither queued nor restarts the conversion.
- start held high: a new conversion is accepted on the first IDLE edge, i.e. the edge right after done asserts. Back-to-back conversions are legal.
- value/blank_lz changes during a conversion have no effect.
- reset_n asserted mid-conversion aborts immediately to the reset values. The first start after release begins a clean conversion.
- Arithmetic: the BCD accumulator is exactly DIGITS*4 bits. The parameter constraint guarantees no carry out of the top nibble, so no overflow handling is required.

Test Plan:
- Reset, then start with value=1234, blank_lz=1 -> busy high for 17 cycles; done pulse 18 edges after start. Digits MS->LS = 15,1,2,3,4; sign_code=15. Outputs stay at reset values (all 15) until done.
- value=-32768, blank_lz=0 -> digits 3,2,7,6,8; sign_code=11. Then value=32767, blank_lz=0 -> 3,2,7,6,7; sign_code=15.
- value=0, blank_lz=1 -> digits 15,15,15,15,0; sign_code=15. Then value=-1, blank_lz=1 -> 15,15,15,15,1; sign_code=11. Then value=-7, blank_lz=0 -> 0,0,0,0,7; sign_code=11.
- start=1 with value=1234, then value changed to 999 and start pulsed again at cycles 3 and 10 of busy -> single done pulse, result 1234. Following IDLE start with 999 -> 15,15,9,9,9.
- start held high continuously with value=42, blank_lz=1 -> done pulses every 18 edges, each result 15,15,15,4,2; no cycle with busy=0 between conversions except the done cycle.
- reset_n dropped asynchronously (between edges) mid-SHIFT of a conversion of 5555 -> busy, done, sign_code and all digit nibbles go to reset values immediately. After release, convert -250 with blank_lz=1 -> digits 15,15,2,5,0; sign_code=11.
